// File: rtl/traffic_light_monitor.sv
// Safety monitor for the intersection light bus: flags illegal codes, conflicts, bad sequencing
// and short yellows, then latches a fault and forces all-red. Optional macro: TLM_GREEN_WATCHDOG_EN.
module traffic_light_monitor #(
    parameter int unsigned MIN_YELLOW = 5,
    parameter int unsigned MAX_GREEN  = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  LA,
    input  logic [1:0]  LB,
    input  logic        clear_fault,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        override,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {MonInit, MonRun, MonFault} state_e;

    localparam logic [1:0] Red    = 2'b00;
    localparam logic [1:0] Yellow = 2'b01;
    localparam logic [1:0] Green  = 2'b10;
    localparam logic [1:0] Bad    = 2'b11;
    localparam logic [CNT_W-1:0] DwellMax = '1;

    if (MAX_GREEN > (2 ** CNT_W) - 1) begin : g_bad_max_green
        $error("MAX_GREEN does not fit in the dwell counter");
    end

    state_e           state_q, state_d;
    logic [1:0]       prev_a_q, prev_b_q;
    logic [CNT_W-1:0] dwell_a_q, dwell_b_q, dwell_a_d, dwell_b_d;
    logic [2:0]       fault_code_q, fault_code_d, hit_code;
    logic [15:0]      cycle_count_q, cycle_count_d;

    function automatic logic bad_step(input logic [1:0] p, input logic [1:0] c);
        return (p == Green && c == Red) || (p == Red && c == Yellow) ||
               (p == Yellow && c == Green);
    endfunction

    function automatic logic short_yellow(input logic [1:0] p, input logic [1:0] c,
                                          input logic [CNT_W-1:0] dwell);
        return p == Yellow && c == Red && dwell < CNT_W'(MIN_YELLOW);
    endfunction

    function automatic logic [CNT_W-1:0] next_dwell(input logic [1:0] p, input logic [1:0] c,
                                                    input logic [CNT_W-1:0] dwell);
        if (c != p) return CNT_W'(1);
        return (dwell == DwellMax) ? dwell : dwell + CNT_W'(1);
    endfunction

    // Lowest fault number wins; transition checks need a valid previous sample.
    always_comb begin
        dwell_a_d = next_dwell(prev_a_q, LA, dwell_a_q);
        dwell_b_d = next_dwell(prev_b_q, LB, dwell_b_q);
        hit_code  = 3'd0;
        if (LA == Bad || LB == Bad) begin
            hit_code = 3'd1;
        end else if (LA != Red && LB != Red) begin
            hit_code = 3'd2;
        end else if (state_q == MonRun) begin
            if (bad_step(prev_a_q, LA) || bad_step(prev_b_q, LB)) begin
                hit_code = 3'd3;
            end else if (short_yellow(prev_a_q, LA, dwell_a_q) ||
                         short_yellow(prev_b_q, LB, dwell_b_q)) begin
                hit_code = 3'd4;
`ifdef TLM_GREEN_WATCHDOG_EN
            end else if ((LA == Green && dwell_a_d == CNT_W'(MAX_GREEN)) ||
                         (LB == Green && dwell_b_d == CNT_W'(MAX_GREEN))) begin
                hit_code = 3'd5;
`endif
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        fault_code_d  = fault_code_q;
        cycle_count_d = cycle_count_q;
        unique case (state_q)
            MonInit, MonRun: begin
                if (hit_code != 3'd0) begin
                    state_d      = MonFault;
                    fault_code_d = hit_code;
                end else begin
                    state_d = MonRun;
                    if (state_q == MonRun && prev_b_q == Yellow && LB == Red) begin
                        cycle_count_d = cycle_count_q + 16'd1;
                    end
                end
            end
            MonFault: begin
                if (clear_fault && LA == Red && LB == Red) begin
                    state_d      = MonInit;
                    fault_code_d = 3'd0;
                end
            end
            default: state_d = MonInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MonInit;
            fault_code_q  <= 3'd0;
            cycle_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            fault_code_q  <= fault_code_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // Per-approach tracking is frozen while faulted; MonInit re-seeds it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_a_q  <= Red;
            prev_b_q  <= Red;
            dwell_a_q <= '0;
            dwell_b_q <= '0;
        end else if (state_q == MonInit) begin
            prev_a_q  <= LA;
            prev_b_q  <= LB;
            dwell_a_q <= CNT_W'(1);
            dwell_b_q <= CNT_W'(1);
        end else if (state_q == MonRun) begin
            prev_a_q  <= LA;
            prev_b_q  <= LB;
            dwell_a_q <= dwell_a_d;
            dwell_b_q <= dwell_b_d;
        end
    end

    always_comb begin
        fault       = (state_q == MonFault);
        override    = (state_q == MonFault);
        fault_code  = fault_code_q;
        cycle_count = cycle_count_q;
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus biased random light sequences,
// all checked against a rule-level reference model.
module tb_traffic_light_monitor;

    localparam int MinYellow = 5;
    localparam int MaxGreen  = 64;
`ifdef TLM_GREEN_WATCHDOG_EN
    localparam bit WdEn = 1'b1;
`else
    localparam bit WdEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear_fault = 1'b0;
    logic [1:0]  LA = 2'b00;
    logic [1:0]  LB = 2'b00;
    logic        fault;
    logic [2:0]  fault_code;
    logic        override;
    logic [15:0] cycle_count;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = first sample, 1 = checking, 2 = faulted.
    int m_mode = 0;
    int m_code = 0;
    int m_cnt  = 0;
    int m_prev[2];
    int m_run[2];

    traffic_light_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .LA          (LA),
        .LB          (LB),
        .clear_fault (clear_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .override    (override),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Codes: 0 red, 1 yellow, 2 green. The legal order green->yellow->red->green steps by -1
    // mod 3, so a step of +1 mod 3 is exactly the illegal set.
    task automatic model(input int rst, input int la, input int lb, input int clr);
        int cur[2];
        int nr[2];
        int f;
        bit c3, c4, c5;
        cur[0] = la;
        cur[1] = lb;
        if (rst != 0) begin
            m_mode = 0; m_code = 0; m_cnt = 0;
            m_prev[0] = 0; m_prev[1] = 0; m_run[0] = 0; m_run[1] = 0;
            return;
        end
        if (m_mode == 2) begin
            if (clr != 0 && la == 0 && lb == 0) begin
                m_mode = 0;
                m_code = 0;
            end
            return;
        end
        c3 = 0; c4 = 0; c5 = 0; f = 0;
        for (int i = 0; i < 2; i++) begin
            nr[i] = (cur[i] == m_prev[i]) ? ((m_run[i] >= 255) ? 255 : m_run[i] + 1) : 1;
            if (cur[i] == (m_prev[i] + 1) % 3) c3 = 1;
            if (m_prev[i] == 1 && cur[i] == 0 && m_run[i] < MinYellow) c4 = 1;
            if (WdEn && cur[i] == 2 && nr[i] == MaxGreen) c5 = 1;
        end
        if (la == 3 || lb == 3) f = 1;
        else if (la != 0 && lb != 0) f = 2;
        else if (m_mode == 1) begin
            if (c3) f = 3;
            else if (c4) f = 4;
            else if (c5) f = 5;
        end
        if (f != 0) begin
            m_mode = 2;
            m_code = f;
            return;
        end
        if (m_mode == 1 && m_prev[1] == 1 && lb == 0) m_cnt = (m_cnt + 1) % 65536;
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = (m_mode == 0) ? 1 : nr[i];
            m_prev[i] = cur[i];
        end
        m_mode = 1;
    endtask

    task automatic step(input int la, input int lb, input int clr, input int rst);
        @(negedge clk);
        LA          = la[1:0];
        LB          = lb[1:0];
        clear_fault = clr[0];
        reset       = rst[0];
        @(posedge clk);
        model(rst, la, lb, clr);
        #1;
        check("m_fault", {31'd0, fault}, {31'd0, m_mode == 2});
        check("m_override", {31'd0, override}, {31'd0, m_mode == 2});
        check("m_fault_code", {29'd0, fault_code}, m_code);
        check("m_cycle_count", {16'd0, cycle_count}, m_cnt);
    endtask

    task automatic hold(input int la, input int lb, input int n);
        repeat (n) step(la, lb, 0, 0);
    endtask

    initial begin
        int g_ap, g_ph, g_left, code, la, lb, clr, rst, exp_wd;
        m_prev[0] = 0; m_prev[1] = 0; m_run[0] = 0; m_run[1] = 0;

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_fault", {31'd0, fault}, 0);
        check("rst_code", {29'd0, fault_code}, 0);
        check("rst_count", {16'd0, cycle_count}, 0);

        repeat (3) begin
            hold(2, 0, 10); hold(1, 0, 6); hold(0, 0, 1);
            hold(0, 2, 8);  hold(0, 1, 6); hold(0, 0, 1);
        end
        check("legal_count", {16'd0, cycle_count}, 3);
        check("legal_fault", {31'd0, fault}, 0);

        step(2, 1, 0, 0);
        check("conflict_code", {29'd0, fault_code}, 2);
        check("conflict_override", {31'd0, override}, 1);
        hold(0, 0, 3);
        check("conflict_latched", {29'd0, fault_code}, 2);

        step(2, 0, 1, 0);
        check("clear_ignored", {31'd0, fault}, 1);
        step(0, 0, 1, 0);
        check("clear_fault", {31'd0, fault}, 0);
        check("clear_keeps_count", {16'd0, cycle_count}, 3);

        hold(2, 0, 3); hold(1, 0, MinYellow - 1); step(0, 0, 0, 0);
        check("short_yellow", {29'd0, fault_code}, 4);
        step(0, 0, 1, 0);
        hold(2, 0, 3); hold(1, 0, MinYellow); step(0, 0, 0, 0);
        check("min_yellow_ok", {31'd0, fault}, 0);

        step(3, 2, 0, 0);
        check("simul_code", {29'd0, fault_code}, 1);
        step(2, 0, 0, 0); step(0, 0, 0, 0);
        check("first_fault_kept", {29'd0, fault_code}, 1);
        step(0, 0, 1, 0);

        step(3, 0, 0, 0);
        check("pre_reset_fault", {31'd0, fault}, 1);
        step(0, 0, 0, 1);
        check("reset_fault", {31'd0, fault}, 0);
        check("reset_override", {31'd0, override}, 0);
        check("reset_code", {29'd0, fault_code}, 0);
        check("reset_count", {16'd0, cycle_count}, 0);

        hold(2, 0, 200);
        exp_wd = WdEn ? 5 : 0;
        check("watchdog_code", {29'd0, fault_code}, exp_wd);
        step(0, 0, 1, 0);

        g_ap = 0; g_ph = 0; g_left = 1;
        repeat (3000) begin
            code = (g_ph == 0) ? 2 : (g_ph == 1) ? 1 : 0;
            la = (g_ap == 0) ? code : 0;
            lb = (g_ap == 1) ? code : 0;
            g_left--;
            if (g_left == 0) begin
                g_ph++;
                if (g_ph == 3) begin
                    g_ph = 0;
                    g_ap ^= 1;
                end
                g_left = (g_ph == 0) ? int'($urandom_range(12, 1)) :
                         (g_ph == 1) ? int'($urandom_range(7, 3)) : 1;
            end
            if ($urandom_range(39, 0) == 0) la = int'($urandom_range(3, 0));
            if ($urandom_range(39, 0) == 0) lb = int'($urandom_range(3, 0));
            clr = ($urandom_range(7, 0) == 0) ? 1 : 0;
            if (m_mode == 2 && $urandom_range(3, 0) == 0) begin
                la = 0; lb = 0; clr = 1;
            end
            rst = ($urandom_range(599, 0) == 0) ? 1 : 0;
            step(la, lb, clr, rst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
